truth_table_sweeper: RTL

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for N_IMPL implementations of Y = AB' + AC.
// Drives all 8 {A,B,C} vectors with a settle cycle before each compare and
// reports a pass flag, a per-vector error count, a sticky per-implementation
// fail mask and the first failing vector.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   start          in   sweep request, only honoured in IDLE
//   en_mask        in   N_IMPL, bit i includes implementation i in compares
//   y_in           in   N_IMPL, Y outputs of the implementations
//   abc            out  3, registered {A,B,C} stimulus (0 when not sweeping)
//   busy           out  high in APPLY and CHECK
//   done           out  one-cycle pulse in the DONE state
//   pass           out  last sweep had no enabled mismatch
//   err_count      out  4, vectors with at least one enabled mismatch
//   fail_mask      out  N_IMPL, sticky per-implementation mismatch flags
//   first_fail_abc out  3, vector of the first mismatching compare
module truth_table_sweeper #(
    parameter int         N_IMPL   = 6,
    parameter logic [7:0] EXPECTED = 8'hB0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_IMPL-1:0] en_mask,
    input  logic [N_IMPL-1:0] y_in,
    output logic [2:0]        abc,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [3:0]        err_count,
    output logic [N_IMPL-1:0] fail_mask,
    output logic [2:0]        first_fail_abc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [2:0]        idx;
    logic [2:0]        idx_nx;
    logic              ff_seen;
    logic              ff_seen_nx;
    logic [N_IMPL-1:0] mis;
    logic [N_IMPL-1:0] fail_nx;
    logic [3:0]        err_nx;
    logic [2:0]        ff_abc_nx;
    logic              pass_nx;
    logic              busy_nx;
    logic              done_nx;
    logic [2:0]        abc_nx;

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        ff_seen_nx = ff_seen;
        fail_nx    = fail_mask;
        err_nx     = err_count;
        ff_abc_nx  = first_fail_abc;
        pass_nx    = pass;
        mis        = '0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx   = S_APPLY;
                    idx_nx     = 3'd0;
                    ff_seen_nx = 1'b0;
                    fail_nx    = '0;
                    err_nx     = 4'd0;
                    ff_abc_nx  = 3'd0;
                    pass_nx    = 1'b0;
                end
            end
            S_APPLY: begin
                state_nx = S_CHECK;
            end
            S_CHECK: begin
                mis     = en_mask & (y_in ^ {N_IMPL{EXPECTED[idx]}});
                fail_nx = fail_mask | mis;
                if (|mis) begin
                    err_nx = err_count + 4'd1;
                    if (!ff_seen) begin
                        ff_abc_nx  = idx;
                        ff_seen_nx = 1'b1;
                    end
                end
                if (idx == 3'd7) begin
                    state_nx = S_DONE;
                    // Result becomes visible in the DONE cycle itself,
                    // so it must include this final compare.
                    pass_nx  = (err_nx == 4'd0);
                end else begin
                    state_nx = S_APPLY;
                    idx_nx   = idx + 3'd1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                idx_nx   = 3'd0;
            end
            default: begin
                state_nx = S_IDLE;
                idx_nx   = 3'd0;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up
    // with the state they describe.
    always_comb begin
        busy_nx = (state_nx == S_APPLY) || (state_nx == S_CHECK);
        done_nx = (state_nx == S_DONE);
        abc_nx  = busy_nx ? idx_nx : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            idx            <= 3'd0;
            ff_seen        <= 1'b0;
            abc            <= 3'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 4'd0;
            fail_mask      <= '0;
            first_fail_abc <= 3'd0;
        end else begin
            state          <= state_nx;
            idx            <= idx_nx;
            ff_seen        <= ff_seen_nx;
            abc            <= abc_nx;
            busy           <= busy_nx;
            done           <= done_nx;
            pass           <= pass_nx;
            err_count      <= err_nx;
            fail_mask      <= fail_nx;
            first_fail_abc <= ff_abc_nx;
        end
    end

endmodule
